fetch_unit: RTL and testbench

//  Instruction-fetch stage feeding the decoder. Holds the PC, issues reads to a

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_fifo.sv | 52 +++++
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

   localparam logic [31:0] INST_NOP       = 32'h0000_0013;
   localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
   localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(
      input logic [31:0] a
   );
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO of {addr, inst} pairs; flush beats push/pop.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  din,
   output fetch_entry_t  head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   function automatic logic [PW-1:0] nxt(
      input logic [PW-1:0] p
   );
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop)  rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, ROM request issue, response buffering, if_id output.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF,
   parameter int          DEPTH      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_flag_i,
   output logic        rom_rd_o,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_data_i,
   input  logic        id_ready_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   pc;
   logic [31:0]   pend_addr;
   logic          pending;
   logic          pop;
   logic          push;
   logic          issue;
   logic [CW:0]   occ;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   fetch_entry_t  head;
   fetch_entry_t  din;

   assign inst_valid_o = ~fifo_empty;
   assign pop  = inst_valid_o & id_ready_i & ~jump_en_i;
   assign push = pending & ~jump_en_i;

   // Reserve a slot for every outstanding read so no response is dropped.
   assign occ = {1'b0, fifo_count}
              + (CW+1)'(pending)
              - (CW+1)'(pop);
   assign issue = ~rst & ~hold_flag_i
                & (occ < (CW+1)'(DEPTH));

   assign rom_rd_o   = issue;
   assign rom_addr_o = jump_en_i ? word_align(jump_addr_i) : pc;

   assign din.addr = pend_addr;
   assign din.inst = rom_data_i;

   assign inst_o      = inst_valid_o ? head.inst : INST_NOP;
   assign inst_addr_o = inst_valid_o ? head.addr : ZERO_WORD;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_ADDR;
         pending   <= 1'b0;
         pend_addr <= ZERO_WORD;
      end else begin
         pending <= issue;
         if (issue) begin
            pc        <= rom_addr_o + 32'd4;
            pend_addr <= rom_addr_o;
         end else begin
            pc <= rom_addr_o;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (jump_en_i),
      .din   (din),
      .head  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst) assert (!(push && fifo_full));
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level model plus directed literal checks.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RA1   = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst0, rst1;
   logic        jump_en, hold, ready;
   logic [31:0] jaddr;
   logic        rd0, rd1, v0, v1;
   logic [31:0] ra0, ra1, rdat0, rdat1;
   logic [31:0] in0, in1, ia0, ia1;

   int applied     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_ADDR(32'h0), .DEPTH(DEPTH)) u0 (
      .clk(clk), .rst(rst0),
      .jump_en_i(jump_en), .jump_addr_i(jaddr),
      .hold_flag_i(hold),
      .rom_rd_o(rd0), .rom_addr_o(ra0), .rom_data_i(rdat0),
      .id_ready_i(ready),
      .inst_valid_o(v0), .inst_o(in0), .inst_addr_o(ia0)
   );

   fetch_unit #(.RESET_ADDR(RA1), .DEPTH(DEPTH)) u1 (
      .clk(clk), .rst(rst1),
      .jump_en_i(jump_en), .jump_addr_i(jaddr),
      .hold_flag_i(hold),
      .rom_rd_o(rd1), .rom_addr_o(ra1), .rom_data_i(rdat1),
      .id_ready_i(ready),
      .inst_valid_o(v1), .inst_o(in1), .inst_addr_o(ia1)
   );

   // ROM[i] = i, one cycle of read latency
   always @(posedge clk) begin
      if (rd0) rdat0 <= ra0 >> 2;
      if (rd1) rdat1 <= ra1 >> 2;
   end

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Model: a plain list of {addr,inst} per instance
   logic [31:0] m_pc [2]    = '{32'h0, RA1};
   logic        m_pend [2]  = '{1'b0, 1'b0};
   logic [31:0] m_paddr [2] = '{32'h0, 32'h0};
   logic [63:0] m_q [2][8];
   int          m_n [2]     = '{0, 0};

   task automatic model_step(
      input int k, input logic r, input logic [31:0] rv,
      input logic rd, input logic [31:0] ad,
      input logic v, input logic [31:0] ins,
      input logic [31:0] ia, input logic [31:0] rdata);
      logic        pop, iss;
      logic [31:0] tgt;
      int          occ;
      string       p;
      p   = (k == 0) ? "u0" : "u1";
      pop = (m_n[k] > 0) && ready && !jump_en;
      occ = m_n[k] + int'(m_pend[k]) - int'(pop);
      iss = !r && !hold && (occ < DEPTH);
      tgt = jump_en ? {jaddr[31:2], 2'b00} : m_pc[k];
      chk({p, ".rom_rd"}, 32'(rd), 32'(iss));
      chk({p, ".rom_addr"}, ad, tgt);
      chk({p, ".valid"}, 32'(v), 32'(m_n[k] > 0));
      chk({p, ".inst"}, ins,
          (m_n[k] > 0) ? m_q[k][0][31:0] : INST_NOP);
      chk({p, ".inst_addr"}, ia,
          (m_n[k] > 0) ? m_q[k][0][63:32] : 32'h0);
      if (r) begin
         m_pc[k] = rv; m_pend[k] = 1'b0; m_n[k] = 0;
      end else begin
         if (jump_en) m_n[k] = 0;
         else begin
            if (pop) begin
               for (int i = 0; i < 7; i++) m_q[k][i] = m_q[k][i+1];
               m_n[k]--;
            end
            if (m_pend[k] && m_n[k] < 8) begin
               m_q[k][m_n[k]] = {m_paddr[k], rdata};
               m_n[k]++;
            end
         end
         if (iss) begin
            m_pc[k] = tgt + 32'd4; m_paddr[k] = tgt; m_pend[k] = 1'b1;
         end else begin
            m_pc[k] = tgt; m_pend[k] = 1'b0;
         end
      end
   endtask

   always @(negedge clk) begin
      model_step(0, rst0, 32'h0, rd0, ra0, v0, in0, ia0, rdat0);
      model_step(1, rst1, RA1,   rd1, ra1, v1, in1, ia1, rdat1);
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_valid0(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (!v0 && n < 10) begin step(); @(negedge clk); n++; end
      if (!v0) begin
         applied++; miscompares++;
         $display("FAIL %s: no valid within 10 cycles", nm);
      end
   endtask

   initial begin
      rst0 = 1; rst1 = 1; jump_en = 0; jaddr = 0;
      hold = 0; ready = 1;
      repeat (2) step();
      chk("reset.valid", 32'(v0), 0);
      chk("reset.inst", in0, INST_NOP);
      chk("reset.rd", 32'(rd0), 0);
      // streaming from reset
      rst0 = 0;
      @(negedge clk);
      chk("c0.rd", 32'(rd0), 1);
      chk("c0.addr", ra0, 32'h0);
      step(); @(negedge clk);
      chk("c1.addr", ra0, 32'h4);
      chk("c1.valid", 32'(v0), 0);
      step(); @(negedge clk);
      chk("c2.valid", 32'(v0), 1);
      chk("c2.iaddr", ia0, 32'h0);
      step(); @(negedge clk);
      chk("c3.iaddr", ia0, 32'h4);
      chk("c3.inst", in0, 32'h1);
      repeat (3) step();
      // downstream stall for 5 cycles
      ready = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 2) begin
            chk("stall.rd", 32'(rd0), 0);
            chk("stall.iaddr", ia0, 32'h10);
         end
         step();
      end
      ready = 1;
      @(negedge clk);
      chk("resume.iaddr", ia0, 32'h10);
      chk("resume.addr", ra0, 32'h18);
      step(); @(negedge clk);
      chk("resume.next", ia0, 32'h14);
      // jump while FIFO full
      step(); ready = 0;
      step(); step();
      jump_en = 1; jaddr = 32'h100; ready = 1;
      @(negedge clk);
      chk("jump.addr", ra0, 32'h100);
      step(); jump_en = 0;
      wait_valid0("jump.wait");
      chk("jump.iaddr", ia0, 32'h100);
      chk("jump.inst", in0, 32'h40);
      // jump with a read in flight, unaligned target
      repeat (3) step();
      jump_en = 1; jaddr = 32'h203;
      @(negedge clk);
      chk("jump2.addr", ra0, 32'h200);
      step(); jump_en = 0;
      wait_valid0("jump2.wait");
      chk("jump2.iaddr", ia0, 32'h200);
      // hold for 3 cycles
      repeat (3) step();
      hold = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold.rd", 32'(rd0), 0);
         step();
      end
      hold = 0;
      repeat (4) step();
      // jump together with hold
      jump_en = 1; hold = 1; jaddr = 32'h40;
      @(negedge clk);
      chk("jh.rd", 32'(rd0), 0);
      step(); jump_en = 0;
      step(); step();
      hold = 0;
      @(negedge clk);
      chk("jh.rd_after", 32'(rd0), 1);
      chk("jh.addr", ra0, 32'h40);
      repeat (4) step();
      // wrap from RESET_ADDR near top of space
      rst0 = 1; rst1 = 0;
      @(negedge clk);
      chk("wrap.a0", ra1, 32'hFFFF_FFF8);
      step(); @(negedge clk);
      chk("wrap.a1", ra1, 32'hFFFF_FFFC);
      step(); @(negedge clk);
      chk("wrap.a2", ra1, 32'h0);
      chk("wrap.i0", ia1, 32'hFFFF_FFF8);
      chk("wrap.d0", in1, 32'h3FFF_FFFE);
      step(); @(negedge clk);
      chk("wrap.a3", ra1, 32'h4);
      step(); @(negedge clk);
      chk("wrap.i2", ia1, 32'h0);
      step(); rst1 = 1;
      @(negedge clk);
      chk("mrst.rd", 32'(rd1), 0);
      step(); @(negedge clk);
      chk("mrst.valid", 32'(v1), 0);
      step(); rst1 = 0;
      @(negedge clk);
      chk("mrst.restart", ra1, RA1);
      chk("mrst.rd2", 32'(rd1), 1);
      repeat (4) step();
      @(negedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==",
               applied, miscompares);
      $finish;
   end

endmodule
